inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch / program-load sequencer with 32x16 instruction memory
//
// Purpose: holds a 32-word instruction store that is filled in LOAD mode and
// then fetched from in RUN mode, either free-running or one instruction per
// rising edge of step. A 16'hFFFF word stops execution in HALT.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   load_en, load_valid    program-load request and word strobe
//   load_ready             high only in LOAD
//   load_addr, load_data   instruction memory write port
//   run                    start execution at address 0 (IDLE/HALT only)
//   step_mode, step        single-step control
//   next_inst_addr         next PC from the datapath
//   curr_inst_addr         current PC
//   curr_inst              current instruction (zero outside RUN)
//   inst_valid             instruction commits this cycle
//   halted                 high only in HALT
//   state                  IDLE=00, LOAD=01, RUN=10, HALT=11
//   inst_count             retired-instruction counter, saturating at 255

module inst_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [4:0]  load_addr,
    input  logic [15:0] load_data,
    input  logic        run,
    input  logic        step_mode,
    input  logic        step,
    input  logic [4:0]  next_inst_addr,
    output logic [4:0]  curr_inst_addr,
    output logic [15:0] curr_inst,
    output logic        inst_valid,
    output logic        halted,
    output logic [1:0]  state,
    output logic [7:0]  inst_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_HALT = 2'b11
    } state_t;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    state_t      state_q, state_d;
    logic [4:0]  pc_q, pc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        step_prev_q, step_prev_d;

    logic [15:0] mem [32];

    logic        in_run;
    logic [15:0] fetch_word;
    logic        issue;
    logic        is_halt;
    logic        commit;

    // Instruction store is deliberately not reset so a program survives a
    // reset. Writes only happen in LOAD, and an asserted reset has already
    // forced the state out of LOAD, so no write can slip in with reset.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && load_valid) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        in_run     = (state_q == S_RUN);
        fetch_word = in_run ? mem[pc_q] : 16'h0000;
        // An instruction is offered every cycle in free-run, or only on a
        // 0->1 transition of step in single-step mode.
        issue      = in_run && (!step_mode || (step && !step_prev_q));
        is_halt    = (fetch_word == HALT_WORD);
        commit     = issue && !is_halt;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        step_prev_d = step;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (load_en) begin
                    state_d = S_LOAD;
                end else if (run) begin
                    state_d = S_RUN;
                    pc_d    = 5'd0;
                    cnt_d   = 8'd0;
                end
            end
            S_LOAD: begin
                if (!load_en) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (issue && is_halt) begin
                    state_d = S_HALT;
                end else if (commit) begin
                    pc_d  = next_inst_addr;
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= 5'd0;
            cnt_q       <= 8'd0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            step_prev_q <= step_prev_d;
        end
    end

    assign load_ready     = (state_q == S_LOAD);
    assign halted         = (state_q == S_HALT);
    assign state          = state_q;
    assign curr_inst_addr = pc_q;
    assign curr_inst      = fetch_word;
    assign inst_valid     = commit;
    assign inst_count     = cnt_q;

endmodule
